synth_slot_sequencer: RTL and testbench

Parametrised slot-timing generator for the synth engine, successor to the divided-clock generator plus index counter. It produces single-cycle clock enables instead of toggled derived clocks, so the whole engine runs on AUDIO_CLK. Per active slot it also provides the voice/envelope index, a channel index and frame markers. Free-running and trigger-per-frame modes are supported, with overrun detection. It sits between the audio clock domain root and the oscillator/envelope pipelines.

---
 rtl/synth_timing_pkg.sv | 25 ++
 rtl/synth_ce_prescaler.sv | 44 ++++
 rtl/synth_slot_sequencer.sv | 117 +++++++++++
 tb/tb_synth_slot_sequencer.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_timing_pkg.sv
// rtl/synth_timing_pkg.sv - shared types and sizing helpers for the synth slot timing blocks
package synth_timing_pkg;

  typedef enum logic {SEQ_FREE = 1'b0, SEQ_TRIG = 1'b1} seq_mode_e;
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} seq_state_e;

  // Ceiling log2, never below 1 so a single-value field still has one bit.
  function automatic int clogb2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

  function automatic int slot_width(input int voice_w, input int env_w);
    return voice_w + env_w;
  endfunction

  function automatic int env_div_calc(input longint clk_rate, input longint sample_rate,
                                      input longint channels, input longint voices,
                                      input longint envs);
    return int'(clk_rate / (sample_rate * channels * voices * envs));
  endfunction

endpackage

// File: rtl/synth_ce_prescaler.sv
// rtl/synth_ce_prescaler.sv - modulo-DIV counter with enable and sync clear, registered terminal-count pulse
module synth_ce_prescaler
  import synth_timing_pkg::*;
#(
  parameter int DIV = 6
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic clr_i,
  output logic tc_o,
  output logic tc_next_o
);

  localparam int CW = clogb2(DIV);
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          tc_q;

  always_comb begin
    cnt_d     = cnt_q;
    tc_next_o = 1'b0;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d     = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
      tc_next_o = (cnt_d == LAST);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      tc_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tc_q  <= tc_next_o;
    end
  end

  assign tc_o = tc_q;

endmodule

// File: rtl/synth_slot_sequencer.sv
// rtl/synth_slot_sequencer.sv - slot/channel sequencer producing env/osc clock enables and frame markers
module synth_slot_sequencer
  import synth_timing_pkg::*;
#(
  parameter int VOICE_WIDTH    = 5,
  parameter int ENV_WIDTH      = 3,
  parameter int OSC_RATIO      = 2,
  parameter int SYNTH_CHANNELS = 1,
  parameter int ENV_DIV        = 6,
  parameter int TRIG_MODE      = 0
) (
  input  logic                                        AUDIO_CLK,
  input  logic                                        reset_reg_N,
  input  logic                                        trig,
  input  logic                                        ovr_clr,
  output logic                                        env_ce,
  output logic                                        osc_ce,
  output logic [slot_width(VOICE_WIDTH, ENV_WIDTH)-1:0] xxxx,
  output logic [clogb2(SYNTH_CHANNELS)-1:0]           ch,
  output logic                                        xxxx_zero,
  output logic                                        frame_done,
  output logic                                        run,
  output logic                                        overrun
);

  localparam int SW  = slot_width(VOICE_WIDTH, ENV_WIDTH);
  localparam int CHW = clogb2(SYNTH_CHANNELS);
  localparam bit TRIGGERED = (TRIG_MODE == int'(SEQ_TRIG));
  localparam logic [CHW-1:0] CH_LAST  = CHW'(SYNTH_CHANNELS - 1);
  localparam logic [SW-1:0]  OSC_MASK = SW'(OSC_RATIO - 1);

  seq_state_e     state_q, state_d;
  logic           trig_q, armed_q;
  logic [SW-1:0]  xxxx_q, xxxx_d;
  logic [CHW-1:0] ch_q, ch_d;
  logic           zero_q, osc_q, osc_d, fd_q, fd_d, ovr_q, ovr_d;
  logic           rise, run_q, run_d, env_ce_w, tc_next;

  // armed_q keeps a trig held through reset release from looking like an edge.
  always_comb begin
    rise    = trig && !trig_q && armed_q;
    state_d = state_q;
    if (TRIGGERED) begin
      case (state_q)
        ST_IDLE: if (rise) state_d = ST_RUN;
        ST_RUN:  if (fd_q && !rise) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end else begin
      state_d = ST_RUN;
    end
    run_q = (state_q == ST_RUN);
    run_d = (state_d == ST_RUN);
  end

  // The prescaler sits at 0 on the entry cycle so the first slot is a full ENV_DIV long.
  synth_ce_prescaler #(.DIV(ENV_DIV)) u_prescaler (
    .clk_i     (AUDIO_CLK),
    .rst_ni    (reset_reg_N),
    .en_i      (run_q && run_d),
    .clr_i     (!run_d),
    .tc_o      (env_ce_w),
    .tc_next_o (tc_next)
  );

  always_comb begin
    xxxx_d = xxxx_q;
    ch_d   = ch_q;
    if (!run_d) begin
      xxxx_d = '0;
      ch_d   = '0;
    end else if (env_ce_w) begin
      xxxx_d = xxxx_q + 1'b1;
      if (&xxxx_q) ch_d = (ch_q == CH_LAST) ? '0 : ch_q + 1'b1;
    end
    osc_d = tc_next && ((xxxx_d & OSC_MASK) == OSC_MASK);
    fd_d  = tc_next && (&xxxx_d) && (ch_d == CH_LAST);
    // A set in the same cycle as a clear wins.
    if (TRIGGERED && run_q && rise && !fd_q) ovr_d = 1'b1;
    else if (ovr_clr)                        ovr_d = 1'b0;
    else                                     ovr_d = ovr_q;
  end

  always_ff @(posedge AUDIO_CLK or negedge reset_reg_N) begin
    if (!reset_reg_N) begin
      state_q <= ST_IDLE;
      trig_q  <= 1'b0;
      armed_q <= 1'b0;
      xxxx_q  <= '0;
      ch_q    <= '0;
      zero_q  <= 1'b0;
      osc_q   <= 1'b0;
      fd_q    <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      trig_q  <= trig;
      armed_q <= 1'b1;
      xxxx_q  <= xxxx_d;
      ch_q    <= ch_d;
      zero_q  <= (xxxx_q == '0);
      osc_q   <= osc_d;
      fd_q    <= fd_d;
      ovr_q   <= ovr_d;
    end
  end

  assign env_ce     = env_ce_w;
  assign osc_ce     = osc_q;
  assign xxxx       = xxxx_q;
  assign ch         = ch_q;
  assign xxxx_zero  = zero_q;
  assign frame_done = fd_q;
  assign run        = run_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_synth_slot_sequencer.sv
// tb/tb_synth_slot_sequencer.sv - scoreboard bench for free-run, triggered and 3-channel/OSC_RATIO=1 variants
module tb_synth_slot_sequencer;

  typedef struct {
    int c;
    int x;
    int ch;
    bit osc;
    bit fd;
  } ev_t;

  logic clk = 1'b0;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   rb;

  logic rst_f, rst_t, trig_t, clr_t;

  logic       f_env, f_osc, f_zero, f_fd, f_run, f_ovr;
  logic [2:0] f_xx;
  logic [0:0] f_ch;
  logic       t_env, t_osc, t_zero, t_fd, t_run, t_ovr;
  logic [2:0] t_xx;
  logic [0:0] t_ch;
  logic       v_env, v_osc, v_zero, v_fd, v_run, v_ovr;
  logic [2:0] v_xx;
  logic [1:0] v_ch;

  ev_t q_f[$];
  ev_t q_t[$];
  ev_t q_v[$];
  ev_t e_f, e_t, e_v;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  synth_slot_sequencer #(.VOICE_WIDTH(2), .ENV_WIDTH(1), .OSC_RATIO(2), .SYNTH_CHANNELS(2),
                         .ENV_DIV(3), .TRIG_MODE(0)) u_free (
    .AUDIO_CLK(clk), .reset_reg_N(rst_f), .trig(trig_t), .ovr_clr(clr_t),
    .env_ce(f_env), .osc_ce(f_osc), .xxxx(f_xx), .ch(f_ch), .xxxx_zero(f_zero),
    .frame_done(f_fd), .run(f_run), .overrun(f_ovr)
  );

  synth_slot_sequencer #(.VOICE_WIDTH(2), .ENV_WIDTH(1), .OSC_RATIO(2), .SYNTH_CHANNELS(2),
                         .ENV_DIV(3), .TRIG_MODE(1)) u_trig (
    .AUDIO_CLK(clk), .reset_reg_N(rst_t), .trig(trig_t), .ovr_clr(clr_t),
    .env_ce(t_env), .osc_ce(t_osc), .xxxx(t_xx), .ch(t_ch), .xxxx_zero(t_zero),
    .frame_done(t_fd), .run(t_run), .overrun(t_ovr)
  );

  synth_slot_sequencer #(.VOICE_WIDTH(2), .ENV_WIDTH(1), .OSC_RATIO(1), .SYNTH_CHANNELS(3),
                         .ENV_DIV(3), .TRIG_MODE(0)) u_var (
    .AUDIO_CLK(clk), .reset_reg_N(rst_f), .trig(trig_t), .ovr_clr(clr_t),
    .env_ce(v_env), .osc_ce(v_osc), .xxxx(v_xx), .ch(v_ch), .xxxx_zero(v_zero),
    .frame_done(v_fd), .run(v_run), .overrun(v_ovr)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d exp %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // One triggered frame: trig driven after edge t is sampled at t+1, first env_ce lands at t+3.
  function automatic void push_trig(input int t, input int n);
    for (int k = 0; k < n; k++)
      q_t.push_back('{t + 3 + 3 * k, k % 8, k / 8, (k % 2) == 1, k == 15});
  endfunction

  function automatic void push_free(input int r, input int stop);
    for (int k = 0; r + 3 + 3 * k <= stop; k++) begin
      q_f.push_back('{r + 3 + 3 * k, k % 8, (k / 8) % 2, (k % 2) == 1, (k % 16) == 15});
      q_v.push_back('{r + 3 + 3 * k, k % 8, (k / 8) % 3, 1'b1, (k % 24) == 23});
    end
  endfunction

  always @(negedge clk) begin
    if (f_env) begin
      if (q_f.size() == 0) check_eq("free_extra_env", f_env, 0);
      else begin
        e_f = q_f.pop_front();
        check_eq("free_env_cyc", cyc, e_f.c);
        check_eq("free_xxxx", f_xx, e_f.x);
        check_eq("free_ch", f_ch, e_f.ch);
        check_eq("free_osc", f_osc, e_f.osc);
        check_eq("free_fd", f_fd, e_f.fd);
      end
    end else begin
      check_eq("free_osc_alone", f_osc, 0);
      check_eq("free_fd_alone", f_fd, 0);
    end
    check_eq("free_overrun", f_ovr, 0);
  end

  always @(negedge clk) begin
    if (t_env) begin
      if (q_t.size() == 0) check_eq("trig_extra_env", t_env, 0);
      else begin
        e_t = q_t.pop_front();
        check_eq("trig_env_cyc", cyc, e_t.c);
        check_eq("trig_xxxx", t_xx, e_t.x);
        check_eq("trig_ch", t_ch, e_t.ch);
        check_eq("trig_osc", t_osc, e_t.osc);
        check_eq("trig_fd", t_fd, e_t.fd);
      end
    end else begin
      check_eq("trig_osc_alone", t_osc, 0);
      check_eq("trig_fd_alone", t_fd, 0);
    end
  end

  always @(negedge clk) begin
    check_eq("var_osc_eq_env", v_osc, v_env);
    if (v_env) begin
      if (q_v.size() == 0) check_eq("var_extra_env", v_env, 0);
      else begin
        e_v = q_v.pop_front();
        check_eq("var_env_cyc", cyc, e_v.c);
        check_eq("var_xxxx", v_xx, e_v.x);
        check_eq("var_ch", v_ch, e_v.ch);
        check_eq("var_fd", v_fd, e_v.fd);
      end
    end
  end

  initial begin
    rst_f = 1'b0; rst_t = 1'b0; trig_t = 1'b0; clr_t = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_free", {f_env, f_osc, f_xx, f_ch, f_zero, f_fd, f_run, f_ovr}, 0);
    check_eq("rst_trig", {t_env, t_osc, t_xx, t_ch, t_zero, t_fd, t_run, t_ovr}, 0);
    check_eq("rst_var", {v_env, v_osc, v_xx, v_ch, v_zero, v_fd, v_run, v_ovr}, 0);
    rst_f = 1'b1; rst_t = 1'b1;
    rb = cyc;
    push_free(rb, rb + 200);
    check_eq("free_run_pre", f_run, 0);
    wait_cyc(rb + 1);
    check_eq("free_run_clk1", f_run, 1);
    check_eq("trig_idle_run", t_run, 0);

    // single triggered frame
    wait_cyc(rb + 10);
    trig_t = 1'b1; push_trig(rb + 10, 16);
    check_eq("single_run_pre", t_run, 0);
    wait_cyc(rb + 11);
    trig_t = 1'b0;
    check_eq("single_run_on", t_run, 1);
    wait_cyc(rb + 58);
    check_eq("single_run_last", t_run, 1);
    wait_cyc(rb + 59);
    check_eq("single_run_off", t_run, 0);
    wait_cyc(rb + 60);
    check_eq("single_xxxx_after", t_xx, 0);
    check_eq("single_ch_after", t_ch, 0);
    check_eq("single_zero_after", t_zero, 1);

    // back-to-back: second rise lands on the frame_done cycle
    wait_cyc(rb + 70);
    trig_t = 1'b1; push_trig(rb + 70, 16);
    wait_cyc(rb + 71);
    trig_t = 1'b0;
    wait_cyc(rb + 118);
    check_eq("b2b_fd_seen", t_fd, 1);
    trig_t = 1'b1; push_trig(rb + 118, 16);
    wait_cyc(rb + 119);
    trig_t = 1'b0;
    check_eq("b2b_no_gap", t_run, 1);
    wait_cyc(rb + 120);
    check_eq("b2b_overrun", t_ovr, 0);
    wait_cyc(rb + 167);
    check_eq("b2b_run_off", t_run, 0);

    // overrun set, set-wins-over-clear, then clear
    wait_cyc(rb + 180);
    trig_t = 1'b1; push_trig(rb + 180, 16);
    wait_cyc(rb + 181);
    trig_t = 1'b0;
    wait_cyc(rb + 190);
    trig_t = 1'b1;
    check_eq("ovr_pre", t_ovr, 0);
    wait_cyc(rb + 191);
    trig_t = 1'b0;
    check_eq("ovr_set", t_ovr, 1);
    wait_cyc(rb + 200);
    #1 rst_f = 1'b0;
    trig_t = 1'b1; clr_t = 1'b1;
    wait_cyc(rb + 201);
    trig_t = 1'b0; clr_t = 1'b0;
    check_eq("ovr_set_wins", t_ovr, 1);
    wait_cyc(rb + 210);
    clr_t = 1'b1;
    wait_cyc(rb + 211);
    clr_t = 1'b0;
    check_eq("ovr_cleared", t_ovr, 0);
    wait_cyc(rb + 229);
    check_eq("ovr_frame_end", t_run, 0);

    // trig held high for 100 cycles runs exactly one frame
    wait_cyc(rb + 240);
    trig_t = 1'b1; push_trig(rb + 240, 16);
    wait_cyc(rb + 300);
    check_eq("held_run_off", t_run, 0);
    wait_cyc(rb + 340);
    trig_t = 1'b0;
    wait_cyc(rb + 345);
    check_eq("held_still_idle", t_run, 0);
    check_eq("held_no_overrun", t_ovr, 0);

    // reset at slot 5 with trig held high through release
    wait_cyc(rb + 360);
    trig_t = 1'b1; push_trig(rb + 360, 5);
    wait_cyc(rb + 361);
    trig_t = 1'b0;
    wait_cyc(rb + 377);
    check_eq("slot5_reached", t_xx, 5);
    #1 rst_t = 1'b0; trig_t = 1'b1;
    #1 check_eq("midreset_zero", {t_env, t_osc, t_xx, t_ch, t_zero, t_fd, t_run, t_ovr}, 0);
    wait_cyc(rb + 380);
    rst_t = 1'b1;
    wait_cyc(rb + 420);
    check_eq("release_no_frame", t_run, 0);
    trig_t = 1'b0;

    // fresh trigger after reset behaves as from power-up
    wait_cyc(rb + 425);
    trig_t = 1'b1; push_trig(rb + 425, 16);
    wait_cyc(rb + 426);
    trig_t = 1'b0;
    check_eq("post_reset_run", t_run, 1);
    wait_cyc(rb + 474);
    check_eq("post_reset_done", t_run, 0);
    wait_cyc(rb + 480);

    check_eq("q_free_empty", q_f.size(), 0);
    check_eq("q_trig_empty", q_t.size(), 0);
    check_eq("q_var_empty", q_v.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
